// File: rtl/exp4_controle_jogada.sv
// Round controller for the memory game: sequences datapath pulses per key entry
// and reports the round result. Moore FSM with registered outputs and an ESPERA timeout.
module exp4_controle_jogada #(
   parameter int TIMEOUT_CICLOS = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       fimC,
   input  logic       igual,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   localparam int TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CICLOS - 1);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARACAO  = 4'h5,
      PROXIMO     = 4'h6,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } estado_t;

   estado_t       estado_r;
   estado_t       proximo_s;
   logic [TW-1:0] timer_r;
   logic          jogada_d_r;
   logic          borda_s;
   logic [7:0]    saidas_r;

   // Output vector packed as {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
   function automatic logic [7:0] decodifica(input estado_t e);
      logic [7:0] s;
      case (e)
         PREPARACAO:  s = 8'b1010_0000;
         REGISTRA:    s = 8'b0001_0000;
         PROXIMO:     s = 8'b0100_0000;
         FIM_ACERTO:  s = 8'b0000_1100;
         FIM_ERRO:    s = 8'b0000_1010;
         FIM_TIMEOUT: s = 8'b0000_1011;
         default:     s = 8'b0000_0000;
      endcase
      return s;
   endfunction

   assign borda_s = jogada & ~jogada_d_r;

   // Next-state logic; a key edge takes priority over timer expiry
   always_comb begin
      proximo_s = INICIAL;
      case (estado_r)
         INICIAL: begin
            if (iniciar) proximo_s = PREPARACAO;
            else         proximo_s = INICIAL;
         end
         PREPARACAO: proximo_s = ESPERA;
         ESPERA: begin
            if (borda_s)               proximo_s = REGISTRA;
            else if (timer_r == T_MAX) proximo_s = FIM_TIMEOUT;
            else                       proximo_s = ESPERA;
         end
         REGISTRA: proximo_s = COMPARACAO;
         COMPARACAO: begin
            if (!igual)    proximo_s = FIM_ERRO;
            else if (fimC) proximo_s = FIM_ACERTO;
            else           proximo_s = PROXIMO;
         end
         PROXIMO: proximo_s = ESPERA;
         FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: begin
            if (iniciar) proximo_s = PREPARACAO;
            else         proximo_s = estado_r;
         end
         default: proximo_s = INICIAL;
      endcase
   end

   // State, key sampler, saturating timer and outputs decoded from the next state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_r   <= INICIAL;
         timer_r    <= '0;
         jogada_d_r <= 1'b0;
         saidas_r   <= 8'h00;
      end else begin
         estado_r   <= proximo_s;
         jogada_d_r <= jogada;
         saidas_r   <= decodifica(proximo_s);
         case (estado_r)
            PREPARACAO, PROXIMO: timer_r <= '0;
            ESPERA: begin
               if (timer_r != T_MAX) timer_r <= timer_r + TW'(1);
               else                  timer_r <= timer_r;
            end
            default: timer_r <= timer_r;
         endcase
      end
   end

   assign {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} = saidas_r;
   assign db_estado = estado_r;

endmodule

// File: tb/tb_exp4_controle_jogada.sv
// Bench for exp4_controle_jogada: per-cycle vector table, hand-written corner
// sequences, and randomized full rounds checked against a round-level model.
module tb_exp4_controle_jogada;
   localparam int TO = 10;

   logic clock = 1'b0, reset = 1'b0, iniciar = 1'b0, jogada = 1'b0;
   logic fimC, igual;
   logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
   logic [3:0] db_estado;
   logic [7:0] outs;

   logic use_dp = 1'b0, igl_t = 1'b0, fim_t = 1'b0;
   logic [3:0] tecla = 4'h0, addr_q, reg_q;
   int total = 0, bad = 0, n_reg = 0, n_cnt = 0;

   exp4_controle_jogada #(.TIMEOUT_CICLOS(TO)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
      .fimC(fimC), .igual(igual), .zeraC(zeraC), .contaC(contaC),
      .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
      .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   assign outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};

   function automatic logic [3:0] memw(input logic [3:0] a);
      return a * 4'd5 + 4'd3;
   endfunction

   // Datapath stand-in: 16-word memory, address counter and key register
   always @(posedge clock) begin
      if (zeraC === 1'b1) addr_q <= 4'h0;
      else if (contaC === 1'b1) addr_q <= addr_q + 4'h1;
      if (zeraR === 1'b1) reg_q <= 4'h0;
      else if (registraR === 1'b1) reg_q <= tecla;
   end
   assign igual = use_dp ? (reg_q == memw(addr_q)) : igl_t;
   assign fimC  = use_dp ? (addr_q == 4'hF) : fim_t;

   always @(negedge clock) begin
      if (registraR === 1'b1) n_reg <= n_reg + 1;
      if (contaC === 1'b1) n_cnt <= n_cnt + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic ini, jog, igl, fim;
      logic [3:0] est;
      logic [7:0] o;
   } vec_t;
   vec_t tab[23];

   task automatic run_round(input int wrong_idx, input int to_idx);
      int exp_reg, exp_cnt, b_reg, b_cnt, g, k;
      logic [3:0] exp_est;
      logic [7:0] exp_out;
      bit fim;
      if (to_idx < 16 && to_idx <= wrong_idx) begin
         exp_reg = to_idx; exp_cnt = to_idx; exp_est = 4'hD; exp_out = 8'h0B;
      end else if (wrong_idx < 16) begin
         exp_reg = wrong_idx + 1; exp_cnt = wrong_idx; exp_est = 4'hE; exp_out = 8'h0A;
      end else begin
         exp_reg = 16; exp_cnt = 15; exp_est = 4'hA; exp_out = 8'h0C;
      end
      iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
      check("rnd_prep", {db_estado, outs}, {4'h1, 8'hA0});
      b_reg = n_reg; b_cnt = n_cnt;
      fim = 1'b0;
      for (int i = 0; i < 16 && !fim; i++) begin
         k = 0;
         while (db_estado !== 4'h2 && k < 5) begin @(negedge clock); k++; end
         if (db_estado !== 4'h2) begin
            check("rnd_espera", {28'h0, db_estado}, 32'h2);
            fim = 1'b1;
         end else if (i == to_idx) begin
            repeat (TO - 1) @(negedge clock);
            check("rnd_pre_timeout", {28'h0, db_estado}, 32'h2);
            @(negedge clock);
            fim = 1'b1;
         end else begin
            g = $urandom_range(0, TO - 1);
            repeat (g) @(negedge clock);
            tecla = (i == wrong_idx) ? (memw(4'(i)) ^ 4'h1) : memw(4'(i));
            jogada = 1'b1; @(negedge clock); jogada = 1'b0;
            check("rnd_lat_reg", {db_estado, outs}, {4'h4, 8'h10});
            repeat (2) @(negedge clock);
            if (i == wrong_idx || i == 15) fim = 1'b1;
            else check("rnd_proximo", {db_estado, outs}, {4'h6, 8'h40});
         end
      end
      check("rnd_fim", {db_estado, outs}, {exp_est, exp_out});
      @(negedge clock);
      check("rnd_hold", {db_estado, outs}, {exp_est, exp_out});
      check("rnd_regs", n_reg - b_reg, exp_reg);
      check("rnd_contas", n_cnt - b_cnt, exp_cnt);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      //          ini   jog   igl   fim   est    outs
      tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
      tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 8'hA0};
      tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 8'h00};
      tab[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 8'h10};
      tab[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 8'h00};
      tab[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 8'h40};
      tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 8'h00};
      tab[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 8'h00};
      tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 8'h00};
      tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 8'h10};
      tab[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h00};
      tab[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 8'h0C};
      tab[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'h0C};
      tab[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 8'hA0};
      tab[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 8'h00};
      tab[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 8'h10};
      tab[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h00};
      tab[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 8'h0A};
      tab[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 8'h0A};
      tab[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 8'hA0};
      tab[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 8'h00};
      tab[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 8'h00};
      tab[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 8'h00};

      #1;
      check("reset_state", {db_estado, outs}, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 23; i++) begin
         iniciar = tab[i].ini; jogada = tab[i].jog; igl_t = tab[i].igl; fim_t = tab[i].fim;
         @(negedge clock);
         check($sformatf("vec%0d", i), {db_estado, outs}, {tab[i].est, tab[i].o});
      end
      iniciar = 1'b0; jogada = 1'b0; igl_t = 1'b0; fim_t = 1'b0;

      // Timeout: ten idle ESPERA cycles
      reset = 1'b0; #1;
      check("rst_from_espera", {db_estado, outs}, 32'h0);
      @(negedge clock); reset = 1'b1;
      iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
      check("to_prep", {db_estado, outs}, {4'h1, 8'hA0});
      @(negedge clock);
      check("to_cycle1", {28'h0, db_estado}, 32'h2);
      repeat (TO - 1) @(negedge clock);
      check("to_cycle10", {28'h0, db_estado}, 32'h2);
      @(negedge clock);
      check("to_fim", {db_estado, outs}, {4'hD, 8'h0B});
      @(negedge clock);
      check("to_hold", {db_estado, outs}, {4'hD, 8'h0B});

      // Key edge on the last ESPERA cycle wins over expiry
      iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
      check("e10_prep", {db_estado, outs}, {4'h1, 8'hA0});
      @(negedge clock);
      repeat (TO - 1) @(negedge clock);
      jogada = 1'b1; @(negedge clock); jogada = 1'b0;
      check("e10_reg", {db_estado, outs}, {4'h4, 8'h10});
      @(negedge clock);
      check("e10_comp", {db_estado, outs}, {4'h5, 8'h00});
      @(negedge clock);
      check("e10_erro", {db_estado, outs}, {4'hE, 8'h0A});

      // Asynchronous reset while in COMPARACAO
      iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
      @(negedge clock);
      jogada = 1'b1; @(negedge clock); jogada = 1'b0;
      @(negedge clock);
      check("rc_comp", {28'h0, db_estado}, 32'h5);
      igl_t = 1'b1; fim_t = 1'b0;
      #2 reset = 1'b0;
      #1 check("rc_async", {db_estado, outs}, 32'h0);
      #1 reset = 1'b1;
      @(negedge clock);
      check("rc_after_clock", {db_estado, outs}, 32'h0);
      @(negedge clock);
      check("rc_stay_inicial", {db_estado, outs}, 32'h0);
      iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
      check("rc_restart", {db_estado, outs}, {4'h1, 8'hA0});
      reset = 1'b0; @(negedge clock); reset = 1'b1;
      igl_t = 1'b0;

      // Full rounds against the datapath stand-in
      use_dp = 1'b1;
      run_round(99, 99);
      run_round(2, 99);
      run_round(99, 5);
      for (int r = 0; r < 30; r++) begin
         run_round(int'($urandom_range(0, 24)), int'($urandom_range(0, 47)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/exp4_controle_jogada.md
EXP4_CONTROLE_JOGADA -- requirements
Module: exp4_controle_jogada

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CICLOS, default 5000, the number of clock cycles allowed in ESPERA before a timeout.
REQ-002 The block SHALL have these ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start or restart request, level.
- jogada  in  1  any key pressed, level; raw, already synchronized externally.
- fimC  in  1  datapath counter at its last address.
- igual  in  1  datapath register equals the memory word.
- zeraC  out  1  clear the datapath counter.
- contaC  out  1  increment the datapath counter.
- zeraR  out  1  clear the datapath register.
- registraR  out  1  load the key value into the datapath register.
- pronto  out  1  round finished.
- acertou  out  1  round finished with every entry correct.
- errou  out  1  round finished by mismatch or timeout.
- timeout  out  1  round finished by timeout.
- db_estado  out  4  current state code.

Function
REQ-003 The block SHALL be a Moore FSM; every output SHALL depend only on the current state.
REQ-004 State codes (db_estado) SHALL be: INICIAL=0x0, PREPARACAO=0x1, ESPERA=0x2, REGISTRA=0x4, COMPARACAO=0x5, PROXIMO=0x6, FIM_ACERTO=0xA, FIM_TIMEOUT=0xD, FIM_ERRO=0xE.
- All unused codes SHALL go to INICIAL on the next clock.
REQ-005 INICIAL: all outputs 0; iniciar=1 -> PREPARACAO, else stay.
REQ-006 PREPARACAO: zeraC=1, zeraR=1, timer cleared; unconditionally -> ESPERA.
REQ-007 ESPERA: timer increments by 1 per cycle.
- Rising edge of jogada -> REGISTRA; the edge is jogada=1 this cycle and the internal sampled jogada_d=0.
- Otherwise, when the timer equals TIMEOUT_CICLOS-1 -> FIM_TIMEOUT.
- Edge and timer expiry in the same cycle: the edge SHALL win.
REQ-008 The jogada_d register SHALL sample jogada every cycle in every state, so a key held across the previous state does not produce an edge.
REQ-009 REGISTRA: registraR=1 for exactly one cycle; -> COMPARACAO.
REQ-010 COMPARACAO: igual=0 -> FIM_ERRO; igual=1 and fimC=1 -> FIM_ACERTO; igual=1 and fimC=0 -> PROXIMO.
REQ-011 PROXIMO: contaC=1 for exactly one cycle, timer cleared; -> ESPERA.
REQ-012 Terminal-state outputs SHALL be: FIM_ACERTO pronto=1, acertou=1; FIM_ERRO pronto=1, errou=1; FIM_TIMEOUT pronto=1, errou=1, timeout=1.
- All other outputs SHALL be 0 in these states.
- Terminal states SHALL hold until iniciar=1 -> PREPARACAO.
REQ-013 iniciar SHALL be ignored in every state other than INICIAL and the three FIM states.
REQ-014 The timer SHALL be wide enough to hold TIMEOUT_CICLOS-1 and SHALL saturate, never wrap, in any state.
- It SHALL be cleared only in PREPARACAO and PROXIMO.
REQ-015 Latency: jogada edge to registraR=1 SHALL be 1 cycle; registraR to acertou, errou or contaC SHALL be 2 cycles.
REQ-016 At most one of zeraC, contaC, registraR SHALL be 1 in any cycle; at most one of acertou, errou SHALL be 1 in any cycle.

Reset
REQ-017 reset=0 SHALL immediately, without a clock, force state INICIAL, timer=0, jogada_d=0 and all outputs 0, with db_estado=0x0.
REQ-018 reset asserted mid-round SHALL abort the round, and no datapath control pulse SHALL be emitted on the following clock.
REQ-019 After reset is released, the FSM SHALL leave INICIAL only on iniciar=1.

Verification (TIMEOUT_CICLOS=10, 16-word memory, fimC at address 15)
REQ-020 Bench SHALL cover:
- Reset, iniciar=1, 16 correct jogada edges -> 16 registraR pulses, 15 contaC pulses, then pronto=1, acertou=1, db_estado=0xA.
- Wrong key on the 3rd entry (igual=0) -> pronto=1, errou=1, timeout=0, db_estado=0xE, exactly 2 contaC pulses seen.
- No jogada for 10 cycles in ESPERA -> db_estado=0xD, pronto=1, errou=1, timeout=1.
- jogada edge exactly on the 10th ESPERA cycle -> REGISTRA taken, no timeout.
- jogada held high across PROXIMO -> no second registraR until jogada falls and rises again.
- reset=0 during COMPARACAO -> outputs 0 and db_estado=0x0 before the next clock edge; iniciar=1 after release restarts from PREPARACAO with zeraC=1.
